// File: rtl/div_unit_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; div_running stalls the pipeline meanwhile.
module div_unit_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            div_running,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic            rem_sel;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    logic            in_signed;
    logic            in_neg_a;
    logic            in_neg_b;
    logic            in_dz;
    logic            in_ovf;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] spec_res;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_sub;
    logic            ge;
    logic [XLEN-1:0] quo_n;
    logic [XLEN-1:0] rem_n;
    logic [XLEN-1:0] fin_res;

    always_comb begin
        in_signed = ~op[0];
        in_neg_a  = in_signed & op_a[XLEN-1];
        in_neg_b  = in_signed & op_b[XLEN-1];
        abs_a     = in_neg_a ? (~op_a + 1'b1) : op_a;
        abs_b     = in_neg_b ? (~op_b + 1'b1) : op_b;
        in_dz     = (op_b == '0);
        in_ovf    = in_signed & (op_a == MIN_NEG) & (op_b == '1);
        if (in_dz)
            spec_res = op[1] ? op_a : '1;
        else
            spec_res = op[1] ? '0 : MIN_NEG;
    end

    // rem < divisor always holds, so the top bit of rem_sub is a true borrow
    always_comb begin
        rem_sh  = {rem, quo[XLEN-1]};
        rem_sub = rem_sh - {1'b0, divisor};
        ge      = ~rem_sub[XLEN];
        quo_n   = {quo[XLEN-2:0], ge};
        rem_n   = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
        if (rem_sel)
            fin_res = neg_a ? (~rem_n + 1'b1) : rem_n;
        else
            fin_res = (neg_a ^ neg_b) ? (~quo_n + 1'b1) : quo_n;
    end

    assign div_running = nrst & ~flush &
                         (((state == IDLE) & start) | (state == RUN));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            counter <= '0;
            result  <= '0;
            done    <= 1'b0;
            rem_sel <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
        end else if (flush) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rem_sel <= op[1];
                        neg_a   <= in_neg_a;
                        neg_b   <= in_neg_b;
                        divisor <= abs_b;
                        quo     <= abs_a;
                        rem     <= '0;
                        if (in_dz | in_ovf) begin
                            result <= spec_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            counter <= CW'(XLEN - 1);
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    if (counter == '0) begin
                        result <= fin_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
